// File: rtl/vga_timing_pkg.sv
// Shared timing constants, totals helpers and FSM state type for the VGA raster generator.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam bit DEF_SYNC_ACTIVE_LOW = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } vga_state_e;

    function automatic int unsigned h_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned visible, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_controller_if.sv
// Raster bus between the timing controller (master) and the colour-output stage (slave).
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_controller_if;
    import vga_timing_pkg::*;

    logic             pixel_tick;
    logic [CNT_W-1:0] column;
    logic [CNT_W-1:0] row;
    logic             display_enable;
    logic             vga_hsync;
    logic             vga_vsync;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0]      frame_count;

    modport master (
        input  pixel_tick,
        output column, row, display_enable, vga_hsync, vga_vsync, line_start, frame_start,
        output frame_count
    );
    modport slave (
        output pixel_tick,
        input  column, row, display_enable, vga_hsync, vga_vsync, line_start, frame_start,
        input  frame_count
    );
`else
    modport master (
        input  pixel_tick,
        output column, row, display_enable, vga_hsync, vga_vsync, line_start, frame_start
    );
    modport slave (
        output pixel_tick,
        input  column, row, display_enable, vga_hsync, vga_vsync, line_start, frame_start
    );
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap-around counter plus registered visible and sync-window flags.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = 800,
    parameter int unsigned VISIBLE    = 640,
    parameter int unsigned SYNC_START = 656,
    parameter int unsigned SYNC_LEN   = 96
) (
    input  logic             vga_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             visible,
    output logic             sync_window
);

    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_START + SYNC_LEN - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             visible_q, visible_d;
    logic             sync_q, sync_d;

    always_comb begin
        count_d   = count_q;
        visible_d = visible_q;
        sync_d    = sync_q;
        if (restart) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
        // Flags track count_d so they stay aligned with the registered count; they are
        // only refreshed on a step so the idle state keeps visible low at position 0.
        if (restart || enable) begin
            visible_d = (count_d < VIS_END);
            sync_d    = (count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST);
        end
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            visible_q <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            visible_q <= visible_d;
            sync_q    <= sync_d;
        end
    end

    assign count       = count_q;
    assign wrap        = enable && (count_q == LAST);
    assign visible     = visible_q;
    assign sync_window = sync_q;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing generator advancing on pixel_tick; default 640x480@60 (800x525 total).
// Optional macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count on the bus.
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE       = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT         = DEF_H_FRONT,
    parameter int unsigned H_SYNC          = DEF_H_SYNC,
    parameter int unsigned H_BACK          = DEF_H_BACK,
    parameter int unsigned V_VISIBLE       = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT         = DEF_V_FRONT,
    parameter int unsigned V_SYNC          = DEF_V_SYNC,
    parameter int unsigned V_BACK          = DEF_V_BACK,
    parameter bit          SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW
) (
    input logic                     vga_clock,
    input logic                     reset,
    vga_timing_controller_if.master bus
);

    localparam int unsigned H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    vga_state_e state_q, state_d;
    logic       tick;
    logic       start;
    logic       run_tick;

    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap;
    logic             h_visible, v_visible;
    logic             h_sync_window, v_sync_window;

    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    assign tick = bus.pixel_tick;

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        run_tick = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tick) begin
                    start   = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run_tick = tick;
            end
        endcase
    end

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FRONT),
        .SYNC_LEN   (H_SYNC)
    ) u_h_axis (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .enable      (run_tick),
        .restart     (start),
        .count       (h_count),
        .wrap        (h_wrap),
        .visible     (h_visible),
        .sync_window (h_sync_window)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FRONT),
        .SYNC_LEN   (V_SYNC)
    ) u_v_axis (
        .vga_clock   (vga_clock),
        .reset       (reset),
        .enable      (h_wrap & tick),
        .restart     (start),
        .count       (v_count),
        .wrap        (v_wrap),
        .visible     (v_visible),
        .sync_window (v_sync_window)
    );

    assign line_start_d  = start | h_wrap;
    assign frame_start_d = start | v_wrap;

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge vga_clock or negedge reset) begin
        if (!reset) begin
            frame_count_q <= '0;
        end else if (frame_start_d) begin
            frame_count_q <= frame_count_q + 16'd1;
        end
    end

    assign bus.frame_count = frame_count_q;
`endif

    assign bus.column         = h_count;
    assign bus.row            = v_count;
    assign bus.display_enable = h_visible & v_visible;
    // XOR with the polarity bit: an inactive window gives the deasserted level.
    assign bus.vga_hsync      = h_sync_window ^ SYNC_ACTIVE_LOW;
    assign bus.vga_vsync      = v_sync_window ^ SYNC_ACTIVE_LOW;
    assign bus.line_start     = line_start_q;
    assign bus.frame_start    = frame_start_q;

endmodule
